mon_hex_tx: RTL and testbench
=============================

# mon_hex_tx

Monitor-side formatter that converts binary words into ASCII hex text and pushes the characters into the UART transmit FIFO. Sits directly upstream of the UART interface's TX FIFO write port (`tx_wdata` / `tx_wten` / `tx_fifo_full`). The monitor command engine issues one print request per word, and this block serialises it into one FIFO write per character under FIFO backpressure.

## Interface
- `DW`, 32, request data width. Must be a multiple of 4; maximum digit count is `DW/4`.
- `UPPER`, 1: 1 gives hex letters `A`–`F` (0x41–0x46); 0 gives `a`–`f` (0x61–0x66).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  print request present.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_data`  in  DW  word to print.
- `req_ndig`  in  4  digits to print, 1..DW/4. A value of 0 or a value above DW/4 is treated as DW/4.
- `req_last`  in  1  selects the terminator: 1 = end of line, 0 = space separator.
- `tx_fifo_full`  in  1  TX FIFO full; when high, no write may be issued.
- `tx_wten`  out  1  TX FIFO write strobe, one character per cycle.
- `tx_wdata`  out  8  ASCII character being written.
- `busy`  out  1  high whenever the block is not idle (equal to `~req_ready`).

## Operation
- **States:** IDLE, DIGIT, TERM_SP, TERM_CR, TERM_LF.
- **IDLE:**
  - `req_ready` = 1.
  - A request is accepted when `req_valid & req_ready`.
  - On accept:
    - capture `req_data` left-aligned, so the first digit is nibble `ndig-1` at the top of the shift register;
    - load the digit counter with `ndig`;
    - capture `req_last`;
    - go to DIGIT.
- **DIGIT:**
  - `tx_wdata` = ASCII of the top nibble of the shift register.
  - `tx_wten` = `~tx_fifo_full`.
  - On each write: shift the register left by 4 and decrement the counter.
  - After the write with counter = 1, go to the terminator state:
    - TERM_SP if `last` = 0;
    - TERM_CR if `last` = 1 (see Configuration).
- **TERM_SP:** write 0x20, then go to IDLE.
- **TERM_CR:** write 0x0D, then go to TERM_LF.
- **TERM_LF:** write 0x0A, then go to IDLE.
- **Nibble mapping:**
  - 0–9 map to 0x30 + n.
  - 10–15 map to 0x41 + (n−10) when `UPPER` = 1, or 0x61 + (n−10) when `UPPER` = 0.
- **Backpressure:** a state advances only on a cycle with `tx_wten` = 1. While `tx_fifo_full` is high the state and all registers hold, and `tx_wdata` stays stable.
- **Request inputs** are ignored outside IDLE. They are sampled only on the accept cycle.
- **Outputs:**
  - `tx_wten` is a combinational AND of state-is-emitting with `~tx_fifo_full`.
  - `tx_wdata` = 0x00 in IDLE.
- **Reset:** state = IDLE, counters = 0, shift register = 0. This gives `req_ready` = 1, `busy` = 0, `tx_wten` = 0, `tx_wdata` = 0x00, including while reset is asserted. Reset mid-print abandons the word immediately; characters already written stay in the FIFO.

## Timing
- **Accept** in cycle N. The first character write can occur in cycle N+1; there is no dead cycle between characters.
- **Write count:** a request produces `ndig` + 1 writes with a space terminator, or `ndig` + 2 writes with CR/LF.
  - With no backpressure, the last write is in cycle N + `ndig` + 1 (space) or N + `ndig` + 2 (CR/LF).
  - `req_ready` returns to 1 in the following cycle. The earliest next accept is therefore the cycle after the last write.
- **`tx_fifo_full`** is sampled in the same cycle as the write it gates. The FIFO full flag is registered, so back-to-back writes until full is observed are safe with the FIFO's 8-entry depth.

## Configuration
- **`MON_HEX_CRLF_EN` defined:**
  - `req_last` = 1 emits 0x0D then 0x0A;
  - `req_last` = 0 emits 0x20.
- **`MON_HEX_CRLF_EN` undefined:**
  - TERM_CR and TERM_LF are not built;
  - `req_last` = 1 emits no terminator and the block returns to IDLE directly after the final digit;
  - `req_last` = 0 still emits 0x20.

## Structure
- **Shared package `mon_pkg`:**
  - ASCII constants `ASC_SP`, `ASC_CR`, `ASC_LF`, `ASC_0`, `ASC_A`, `ASC_a`;
  - state encoding for `mon_hex_tx` (3 bits).
- **Sub-module `mon_hex2asc`:** combinational, `UPPER` parameter, 4-bit nibble in, 8-bit ASCII out. Reused by the monitor's dump path.

## Test plan
- **Basic word with space, no backpressure.** Request `req_data`=0x12AB_CDEF, `ndig`=8, `last`=0, `tx_fifo_full`=0.
  - Expect 9 consecutive writes: `1 2 A B C D E F` then 0x20.
  - `req_ready` high again 10 cycles after accept.
- **Short field with end of line (`MON_HEX_CRLF_EN` defined).** Request `req_data`=0x0000_003F, `ndig`=2, `last`=1.
  - Expect writes 0x33, 0x46, 0x0D, 0x0A and no other writes.
- **Backpressure.** Hold `tx_fifo_full`=1 for 5 cycles starting at the 3rd digit.
  - `tx_wten`=0 throughout and `tx_wdata` stable at that digit.
  - The sequence resumes unchanged; there are no dropped or duplicated characters.
- **Clamping and `UPPER`=0.** Request `ndig`=0, `req_data`=0xDEAD_BEEF, `UPPER`=0.
  - Expect 8 digits `deadbeef` followed by a space.
- **Request while busy, then reset mid-print.**
  - Assert `req_valid` with new data during DIGIT: it is ignored.
  - Assert `rst_n`=0 during the 4th digit: `tx_wten` drops in the same cycle, `req_ready`=1.
  - Release reset: no further writes until a new request.
- **Back-to-back requests.** Two requests with `req_valid` held high.
  - The second is accepted in the cycle after the first request's last write.
  - Total writes equal the sum of both sequences.

Source files
------------

// File: rtl/mon_pkg.sv
// Shared monitor package: ASCII constants and the hex
// formatter state encoding.
package mon_pkg;

   localparam logic [7:0] ASC_SP = 8'h20;
   localparam logic [7:0] ASC_CR = 8'h0D;
   localparam logic [7:0] ASC_LF = 8'h0A;
   localparam logic [7:0] ASC_0  = 8'h30;
   localparam logic [7:0] ASC_A  = 8'h41;
   localparam logic [7:0] ASC_a  = 8'h61;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DIGIT   = 3'd1,
      ST_TERM_SP = 3'd2,
      ST_TERM_CR = 3'd3,
      ST_TERM_LF = 3'd4
   } hex_state_e;

endpackage

// File: rtl/mon_hex2asc.sv
// Nibble to ASCII hex digit, combinational.
// Ports: nib_i (4b value), asc_o (8b character). UPPER picks A-F/a-f.
module mon_hex2asc
   import mon_pkg::*;
#(
   parameter bit UPPER = 1'b1
) (
   input  logic [3:0] nib_i,
   output logic [7:0] asc_o
);

   localparam logic [7:0] LETTER = UPPER ? ASC_A : ASC_a;

   always_comb begin
      if (nib_i < 4'd10) begin
         asc_o = ASC_0 + {4'd0, nib_i};
      end else begin
         asc_o = LETTER + {4'd0, nib_i} - 8'd10;
      end
   end

endmodule

// File: rtl/mon_hex_tx.sv
// Serialises one word per request into ASCII hex characters,
// one TX FIFO write per cycle, with space or CR/LF terminator.
// Ports: clk, rst_n (async, active-low);
//   req_valid/req_ready/req_data/req_ndig/req_last request side;
//   tx_fifo_full in, tx_wten/tx_wdata FIFO write side; busy = ~req_ready.
// Build option: define MON_HEX_CRLF_EN to emit CR/LF for req_last=1;
//   otherwise req_last=1 ends the word with no terminator.
module mon_hex_tx
   import mon_pkg::*;
#(
   parameter int DW    = 32,
   parameter bit UPPER = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_data,
   input  logic [3:0]    req_ndig,
   input  logic          req_last,
   input  logic          tx_fifo_full,
   output logic          tx_wten,
   output logic [7:0]    tx_wdata,
   output logic          busy
);

   localparam int NDMAX = DW / 4;
   localparam int CW    = $clog2(NDMAX + 1);

   hex_state_e    st_q, st_d;
   logic [DW-1:0] sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;

   logic [CW-1:0] ndig_eff;
   logic [31:0]   shamt;
   logic [DW-1:0] aligned;
   logic [7:0]    dig_asc;
   logic          emit;

   // Out-of-range digit counts print the full word.
   always_comb begin
      if (req_ndig == 4'd0 || 32'(req_ndig) > 32'(NDMAX)) begin
         ndig_eff = CW'(NDMAX);
      end else begin
         ndig_eff = CW'(req_ndig);
      end
   end

   // Left-align so the first digit sits in the top nibble.
   always_comb begin
      shamt   = 32'(DW) - (32'(ndig_eff) << 2);
      aligned = req_data << shamt;
   end

   mon_hex2asc #(
      .UPPER (UPPER)
   ) u_hex2asc (
      .nib_i (sh_q[DW-1 -: 4]),
      .asc_o (dig_asc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_IDLE;
         sh_q   <= '0;
         cnt_q  <= '0;
         last_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
      end
   end

   always_comb begin
      st_d      = st_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      emit      = 1'b0;
      tx_wdata  = 8'h00;
      req_ready = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               sh_d   = aligned;
               cnt_d  = ndig_eff;
               last_d = req_last;
               st_d   = ST_DIGIT;
            end
         end
         ST_DIGIT: begin
            emit     = 1'b1;
            tx_wdata = dig_asc;
            if (!tx_fifo_full) begin
               sh_d  = sh_q << 4;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
`ifdef MON_HEX_CRLF_EN
                  st_d = last_q ? ST_TERM_CR : ST_TERM_SP;
`else
                  st_d = last_q ? ST_IDLE : ST_TERM_SP;
`endif
               end
            end
         end
         ST_TERM_SP: begin
            emit     = 1'b1;
            tx_wdata = ASC_SP;
            if (!tx_fifo_full) begin
               st_d = ST_IDLE;
            end
         end
`ifdef MON_HEX_CRLF_EN
         ST_TERM_CR: begin
            emit     = 1'b1;
            tx_wdata = ASC_CR;
            if (!tx_fifo_full) begin
               st_d = ST_TERM_LF;
            end
         end
         ST_TERM_LF: begin
            emit     = 1'b1;
            tx_wdata = ASC_LF;
            if (!tx_fifo_full) begin
               st_d = ST_IDLE;
            end
         end
`endif
         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

   assign tx_wten = emit & ~tx_fifo_full;
   assign busy    = ~req_ready;

endmodule

// File: tb/tb_mon_hex_tx.sv
// Bench for mon_hex_tx: table of requests plus hand sequences
// for backpressure, busy-ignore, reset and back-to-back accepts.
module tb_mon_hex_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ndig;
   logic        req_last;
   logic        tx_fifo_full;

   logic        rdy_u, wten_u, busy_u;
   logic [7:0]  wd_u;
   logic        rdy_l, wten_l, busy_l;
   logic [7:0]  wd_l;

   int tests = 0;
   int fails = 0;
   int nwr   = 0;

   logic [7:0] q_u[$];
   logic [7:0] q_l[$];

   always #5 clk = ~clk;

   mon_hex_tx #(.DW(32), .UPPER(1'b1)) dut_u (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (rdy_u),
      .req_data     (req_data),
      .req_ndig     (req_ndig),
      .req_last     (req_last),
      .tx_fifo_full (tx_fifo_full),
      .tx_wten      (wten_u),
      .tx_wdata     (wd_u),
      .busy         (busy_u)
   );

   mon_hex_tx #(.DW(32), .UPPER(1'b0)) dut_l (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (rdy_l),
      .req_data     (req_data),
      .req_ndig     (req_ndig),
      .req_last     (req_last),
      .tx_fifo_full (tx_fifo_full),
      .tx_wten      (wten_l),
      .tx_wdata     (wd_l),
      .busy         (busy_l)
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  ndig;
      logic        last;
      int          exp_n;
   } vec_t;

   vec_t vt[7];

   logic [7:0] hexu[16] = '{
      8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
      8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46
   };

   function automatic logic [7:0] tolow(logic [7:0] c);
      return (c >= 8'h41 && c <= 8'h46) ? c + 8'h20 : c;
   endfunction

   // Push the expected characters; maxc < 0 means all of them.
   function automatic int push_exp(logic [31:0] d, logic [3:0] nd,
                                   logic lst, int maxc);
      int n;
      int k;
      logic [7:0] c;
      logic [7:0] seq[$];
      n = (nd == 0 || nd > 8) ? 8 : int'(nd);
      for (int i = n - 1; i >= 0; i--) begin
         c = hexu[d[4*i +: 4]];
         seq.push_back(c);
      end
      if (!lst) begin
         seq.push_back(8'h20);
      end else begin
`ifdef MON_HEX_CRLF_EN
         seq.push_back(8'h0D);
         seq.push_back(8'h0A);
`endif
      end
      k = 0;
      foreach (seq[j]) begin
         if (maxc < 0 || k < maxc) begin
            q_u.push_back(seq[j]);
            q_l.push_back(tolow(seq[j]));
            k++;
         end
      end
      return k;
   endfunction

   task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count cycles from the first post-accept cycle until ready.
   task automatic wait_ready(output int c);
      c = 1;
      while (!rdy_u && c < 200) begin
         tick();
         c++;
      end
      if (!rdy_u) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout got=%0d exp=<200", c);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (wten_u) begin
            nwr++;
            tests++;
            if (q_u.size() == 0) begin
               fails++;
               $display("FAIL extra_write_u got=%h exp=none", wd_u);
            end else if (wd_u !== q_u[0]) begin
               fails++;
               $display("FAIL char_u got=%h exp=%h", wd_u, q_u[0]);
               void'(q_u.pop_front());
            end else begin
               void'(q_u.pop_front());
            end
         end
         if (wten_l) begin
            tests++;
            if (q_l.size() == 0) begin
               fails++;
               $display("FAIL extra_write_l got=%h exp=none", wd_l);
            end else if (wd_l !== q_l[0]) begin
               fails++;
               $display("FAIL char_l got=%h exp=%h", wd_l, q_l[0]);
               void'(q_l.pop_front());
            end else begin
               void'(q_l.pop_front());
            end
         end
      end
   end

   initial begin
      int c;
      int n0;
      int e1;
      int e2;

      vt[0] = '{32'h12AB_CDEF, 4'd8,  1'b0, 9};
`ifdef MON_HEX_CRLF_EN
      vt[1] = '{32'h0000_003F, 4'd2,  1'b1, 4};
      vt[4] = '{32'hFEDC_BA98, 4'd15, 1'b1, 10};
`else
      vt[1] = '{32'h0000_003F, 4'd2,  1'b1, 2};
      vt[4] = '{32'hFEDC_BA98, 4'd15, 1'b1, 8};
`endif
      vt[2] = '{32'hDEAD_BEEF, 4'd0,  1'b0, 9};
      vt[3] = '{32'h0000_0005, 4'd1,  1'b0, 2};
      vt[5] = '{32'h0000_A5C3, 4'd4,  1'b0, 5};
      vt[6] = '{32'h7654_3210, 4'd9,  1'b0, 9};

      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_data     = '0;
      req_ndig     = '0;
      req_last     = 1'b0;
      tx_fifo_full = 1'b0;
      #3;
      check("rst_ready", 32'(rdy_u), 32'd1);
      check("rst_busy", 32'(busy_u), 32'd0);
      check("rst_wten", 32'(wten_u), 32'd0);
      check("rst_wdata", 32'(wd_u), 32'h00);
      check("rst_wdata_l", 32'(wd_l), 32'h00);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      foreach (vt[i]) begin
         n0 = nwr;
         req_data  = vt[i].data;
         req_ndig  = vt[i].ndig;
         req_last  = vt[i].last;
         req_valid = 1'b1;
         void'(push_exp(vt[i].data, vt[i].ndig, vt[i].last, -1));
         tick();
         req_valid = 1'b0;
         wait_ready(c);
         check($sformatf("vec%0d_latency", i), 32'(c), 32'(vt[i].exp_n + 1));
         check($sformatf("vec%0d_writes", i), 32'(nwr - n0), 32'(vt[i].exp_n));
         tick();
      end

      // Backpressure from the third digit for five cycles.
      n0 = nwr;
      req_data  = 32'h12AB_CDEF;
      req_ndig  = 4'd8;
      req_last  = 1'b0;
      req_valid = 1'b1;
      void'(push_exp(32'h12AB_CDEF, 4'd8, 1'b0, -1));
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tx_fifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_wten", 32'(wten_u), 32'd0);
         check("bp_wdata_u", 32'(wd_u), 32'h41);
         check("bp_wdata_l", 32'(wd_l), 32'h61);
         tick();
      end
      tx_fifo_full = 1'b0;
      wait_ready(c);
      check("bp_latency", 32'(c), 32'd8);
      check("bp_writes", 32'(nwr - n0), 32'd9);
      tick();

      // Request while busy is ignored; reset in the 4th digit.
      n0 = nwr;
      req_data  = 32'h12AB_CDEF;
      req_ndig  = 4'd8;
      req_last  = 1'b0;
      req_valid = 1'b1;
      void'(push_exp(32'h12AB_CDEF, 4'd8, 1'b0, 3));
      tick();
      req_data = 32'hFFFF_FFFF;
      req_ndig = 4'd3;
      req_last = 1'b1;
      tick();
      tick();
      req_valid = 1'b0;
      tick();
      check("pre_rst_wdata", 32'(wd_u), 32'h42);
      rst_n = 1'b0;
      #1;
      check("midrst_wten", 32'(wten_u), 32'd0);
      check("midrst_ready", 32'(rdy_u), 32'd1);
      check("midrst_wdata", 32'(wd_u), 32'h00);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("rst_writes", 32'(nwr - n0), 32'd3);
      check("rst_ready_after", 32'(rdy_u), 32'd1);

      // Back-to-back with valid held high.
      n0 = nwr;
      req_data  = 32'h0000_0ABC;
      req_ndig  = 4'd3;
      req_last  = 1'b0;
      req_valid = 1'b1;
      e1 = push_exp(32'h0000_0ABC, 4'd3, 1'b0, -1);
      tick();
      req_data = 32'h0000_0123;
      req_ndig = 4'd3;
      req_last = 1'b1;
      e2 = push_exp(32'h0000_0123, 4'd3, 1'b1, -1);
      wait_ready(c);
      check("b2b_first_latency", 32'(c), 32'd5);
      tick();
      req_valid = 1'b0;
      wait_ready(c);
`ifdef MON_HEX_CRLF_EN
      check("b2b_second_latency", 32'(c), 32'd6);
`else
      check("b2b_second_latency", 32'(c), 32'd4);
`endif
      check("b2b_writes", 32'(nwr - n0), 32'(e1 + e2));
      repeat (3) tick();
      check("queue_empty", 32'(q_u.size() + q_l.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
